// File: rtl/riscv_stage_seq.sv
// One-hot stage sequencer on the single core clock.
// Adds data-memory wait states, trap flush, stall timeout and cycle/instret counters.
module riscv_stage_seq #(
    parameter int NUM_STAGES = 3,
    parameter int MEM_STAGE  = 1,
    parameter int TIMEOUT    = 255,
    parameter int CNT_W      = 64
) (
    input  logic                  clk,
    input  logic                  x_reset,
    input  logic                  run,
    input  logic                  mem_need,
    input  logic                  mem_ready,
    input  logic                  trap,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic                  mem_req,
    output logic                  retire,
    output logic                  flush,
    output logic                  busy,
    output logic                  err,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic [CNT_W-1:0]      instret_cnt
);

    localparam int KW = $clog2(NUM_STAGES);
    localparam logic [KW-1:0]         K_ZERO      = {KW{1'b0}};
    localparam logic [KW-1:0]         K_ONE       = {{(KW-1){1'b0}}, 1'b1};
    localparam logic [KW-1:0]         K_MEM       = KW'(MEM_STAGE);
    localparam logic [KW-1:0]         K_AFTER_MEM = KW'(MEM_STAGE + 1);
    localparam logic [KW-1:0]         K_LAST      = KW'(NUM_STAGES - 1);
    localparam logic [15:0]           WAIT_ZERO   = 16'h0000;
    localparam logic [15:0]           WAIT_ONE    = 16'h0001;
    localparam logic [15:0]           WAIT_LAST   = 16'(TIMEOUT - 1);
    localparam logic [NUM_STAGES-1:0] HOT0        = {{(NUM_STAGES-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [KW-1:0]     k_r;
    logic [KW-1:0]     k_s;
    logic [15:0]       wait_r;
    logic [15:0]       wait_s;
    logic              err_r;
    logic              err_s;
    logic [CNT_W-1:0]  cycle_r;
    logic [CNT_W-1:0]  instret_r;

    logic              active_s;
    logic              at_mem_s;
    logic              at_last_s;
    logic              timeout_s;

    // Decode of the current state shared by outputs and next-state logic
    always_comb begin
        active_s  = (state_r == ST_RUN) || (state_r == ST_MEM_WAIT);
        at_mem_s  = (state_r == ST_RUN) && (k_r == K_MEM);
        at_last_s = (state_r == ST_RUN) && (k_r == K_LAST);
        // mem_ready on the last allowed wait cycle still wins over the timeout
        timeout_s = (state_r == ST_MEM_WAIT) && !trap && !mem_ready && (wait_r == WAIT_LAST);
    end

    // Combinational stage enables and strobes
    always_comb begin
        stage_en = {NUM_STAGES{1'b0}};
        case (state_r)
            ST_RUN:      stage_en = HOT0 << k_r;
            ST_MEM_WAIT: stage_en = HOT0 << K_MEM;
            default:     stage_en = {NUM_STAGES{1'b0}};
        endcase
        mem_req = !trap && ((at_mem_s && mem_need) || (state_r == ST_MEM_WAIT));
        retire  = at_last_s && !trap;
        flush   = (active_s && trap) || timeout_s;
        busy    = active_s;
    end

    // Next-state logic: trap beats mem_ready, which beats the timeout
    always_comb begin
        state_s = state_r;
        k_s     = k_r;
        wait_s  = wait_r;
        err_s   = err_r;
        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    state_s = ST_RUN;
                    k_s     = K_ZERO;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (trap || (k_r == K_LAST)) begin
                    state_s = run ? ST_RUN : ST_IDLE;
                    k_s     = K_ZERO;
                    wait_s  = WAIT_ZERO;
                end else if ((k_r == K_MEM) && mem_need && !mem_ready) begin
                    state_s = ST_MEM_WAIT;
                    wait_s  = WAIT_ZERO;
                end else begin
                    k_s = k_r + K_ONE;
                end
            end
            ST_MEM_WAIT: begin
                if (trap) begin
                    state_s = run ? ST_RUN : ST_IDLE;
                    k_s     = K_ZERO;
                    wait_s  = WAIT_ZERO;
                end else if (mem_ready) begin
                    state_s = ST_RUN;
                    k_s     = K_AFTER_MEM;
                    wait_s  = WAIT_ZERO;
                end else if (timeout_s) begin
                    state_s = ST_ERROR;
                    err_s   = 1'b1;
                    wait_s  = WAIT_ZERO;
                end else begin
                    wait_s = wait_r + WAIT_ONE;
                end
            end
            ST_ERROR: begin
                state_s = ST_ERROR;
            end
            default: begin
                state_s = ST_IDLE;
                k_s     = K_ZERO;
                wait_s  = WAIT_ZERO;
            end
        endcase
    end

    // Sequencer state, sticky error and free-wrapping counters
    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) begin
            state_r   <= ST_IDLE;
            k_r       <= K_ZERO;
            wait_r    <= WAIT_ZERO;
            err_r     <= 1'b0;
            cycle_r   <= {CNT_W{1'b0}};
            instret_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            k_r     <= k_s;
            wait_r  <= wait_s;
            err_r   <= err_s;
            if (active_s) begin
                cycle_r <= cycle_r + CNT_ONE;
            end else begin
                cycle_r <= cycle_r;
            end
            if (retire) begin
                instret_r <= instret_r + CNT_ONE;
            end else begin
                instret_r <= instret_r;
            end
        end
    end

    assign err         = err_r;
    assign cycle_cnt   = cycle_r;
    assign instret_cnt = instret_r;

endmodule

// File: tb/tb_riscv_stage_seq.sv
// Bench for riscv_stage_seq: directed table, hand-written corner sequences and
// randomized traffic against an instruction-level reference model, on two configurations.
module tb_riscv_stage_seq;

    logic clk;
    logic x_reset;
    logic run_a, need_a, rdy_a, trap_a;
    logic run_b, need_b, rdy_b, trap_b;
    logic [2:0]  se_a;
    logic [4:0]  se_b;
    logic mr_a, ret_a, fl_a, busy_a, err_a;
    logic mr_b, ret_b, fl_b, busy_b, err_b;
    logic [63:0] cyc_a, ins_a;
    logic [3:0]  cyc_b, ins_b;

    int n_tests;
    int n_fail;

    riscv_stage_seq #(.NUM_STAGES(3), .MEM_STAGE(1), .TIMEOUT(8), .CNT_W(64)) dut_a (
        .clk(clk), .x_reset(x_reset), .run(run_a), .mem_need(need_a), .mem_ready(rdy_a),
        .trap(trap_a), .stage_en(se_a), .mem_req(mr_a), .retire(ret_a), .flush(fl_a),
        .busy(busy_a), .err(err_a), .cycle_cnt(cyc_a), .instret_cnt(ins_a)
    );

    riscv_stage_seq #(.NUM_STAGES(5), .MEM_STAGE(2), .TIMEOUT(5), .CNT_W(4)) dut_b (
        .clk(clk), .x_reset(x_reset), .run(run_b), .mem_need(need_b), .mem_ready(rdy_b),
        .trap(trap_b), .stage_en(se_b), .mem_req(mr_b), .retire(ret_b), .flush(fl_b),
        .busy(busy_b), .err(err_b), .cycle_cnt(cyc_b), .instret_cnt(ins_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: stg = -1 means idle; dead means stuck after a timeout
    typedef struct packed {
        int n; int m; int to; int cw;
        int stg;
        bit waiting;
        int waited;
        bit dead;
        bit errf;
        longint unsigned cyc;
        longint unsigned ins;
    } mdl_t;

    typedef struct packed {
        logic [7:0] se;
        logic mr, ret, fl, busy, err;
    } exp_t;

    typedef struct packed {
        bit run, need, rdy, trp;
        logic [2:0] se;
        bit mr, ret, fl, busy;
    } vec_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_init(int n, int m, int to, int cw);
        mdl_t s;
        s = '0;
        s.n = n; s.m = m; s.to = to; s.cw = cw;
        s.stg = -1;
        return s;
    endfunction

    function automatic exp_t mdl_out(mdl_t s, bit run, bit need, bit rdy, bit trp);
        exp_t e;
        bit act;
        bit tmo;
        e = '0;
        act = !s.dead && (s.stg >= 0);
        if (act) begin
            e.se   = 8'd1 << s.stg;
            e.busy = 1'b1;
        end
        e.mr  = act && !trp && (s.stg == s.m) && (s.waiting || need);
        e.ret = act && !trp && (s.stg == s.n - 1);
        tmo   = act && s.waiting && !trp && !rdy && (s.waited == s.to - 1);
        e.fl  = (act && trp) || tmo;
        e.err = s.errf;
        return e;
    endfunction

    function automatic mdl_t mdl_next(mdl_t s, bit run, bit need, bit rdy, bit trp);
        mdl_t r;
        longint unsigned mask;
        r = s;
        mask = (s.cw >= 64) ? ~64'd0 : ((64'd1 << s.cw) - 64'd1);
        if (s.dead) begin
            r = s;
        end else if (s.stg < 0) begin
            if (run) r.stg = 0;
        end else begin
            r.cyc = (s.cyc + 64'd1) & mask;
            if (trp) begin
                r.stg = run ? 0 : -1; r.waiting = 1'b0; r.waited = 0;
            end else if (s.waiting) begin
                if (rdy) begin
                    r.stg = s.m + 1; r.waiting = 1'b0; r.waited = 0;
                end else if (s.waited == s.to - 1) begin
                    r.dead = 1'b1; r.errf = 1'b1; r.waiting = 1'b0;
                end else begin
                    r.waited = s.waited + 1;
                end
            end else if ((s.stg == s.m) && need && !rdy) begin
                r.waiting = 1'b1; r.waited = 0;
            end else if (s.stg == s.n - 1) begin
                r.ins = (s.ins + 64'd1) & mask;
                r.stg = run ? 0 : -1;
            end else begin
                r.stg = s.stg + 1;
            end
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic settle();
        exp_t oa, ob;
        #1;
        if (x_reset) begin
            oa = '0; oa.se = 8'(se_a); oa.mr = mr_a; oa.ret = ret_a; oa.fl = fl_a; oa.busy = busy_a; oa.err = err_a;
            ob = '0; ob.se = 8'(se_b); ob.mr = mr_b; ob.ret = ret_b; ob.fl = fl_b; ob.busy = busy_b; ob.err = err_b;
            chk("a_outputs", 64'(oa), 64'(mdl_out(ma, run_a, need_a, rdy_a, trap_a)));
            chk("a_cycle_cnt", cyc_a, ma.cyc);
            chk("a_instret_cnt", ins_a, ma.ins);
            chk("b_outputs", 64'(ob), 64'(mdl_out(mb, run_b, need_b, rdy_b, trap_b)));
            chk("b_cycle_cnt", 64'(cyc_b), mb.cyc);
            chk("b_instret_cnt", 64'(ins_b), mb.ins);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (x_reset) begin
            ma = mdl_next(ma, run_a, need_a, rdy_a, trap_a);
            mb = mdl_next(mb, run_b, need_b, rdy_b, trap_b);
        end else begin
            ma = mdl_init(3, 1, 8, 64);
            mb = mdl_init(5, 2, 5, 4);
        end
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic do_reset();
        x_reset = 1'b0;
        run_a = 1'b0; need_a = 1'b0; rdy_a = 1'b0; trap_a = 1'b0;
        run_b = 1'b0; need_b = 1'b0; rdy_b = 1'b0; trap_b = 1'b0;
        ma = mdl_init(3, 1, 8, 64);
        mb = mdl_init(5, 2, 5, 4);
        @(negedge clk);
        @(negedge clk);
        x_reset = 1'b1;
    endtask

    vec_t tbl[13];
    int nret, last_ret, held, r0_c, ret_c, dead_cnt;
    bit seen15, seen16;
    logic [4:0] one5;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        // run, need, rdy, trap | stage_en, mem_req, retire, flush, busy
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        x_reset = 1'b0;
        run_a = 1'b1; need_a = 1'b1; rdy_a = 1'b0; trap_a = 1'b1;
        run_b = 1'b1; need_b = 1'b1; rdy_b = 1'b0; trap_b = 1'b1;
        #3;
        chk("reset_a_outputs", {se_a, mr_a, ret_a, fl_a, busy_a, err_a}, 64'd0);
        chk("reset_a_counters", cyc_a | ins_a, 64'd0);
        chk("reset_b_outputs", {se_b, mr_b, ret_b, fl_b, busy_b, err_b, cyc_b, ins_b}, 64'd0);
        do_reset();

        // Directed table: trap vs mem_ready, same-cycle ready, run dropped in RUN(1)
        for (int i = 0; i < 13; i++) begin
            run_a = tbl[i].run; need_a = tbl[i].need; rdy_a = tbl[i].rdy; trap_a = tbl[i].trp;
            settle();
            chk($sformatf("tbl%0d", i), {se_a, mr_a, ret_a, fl_a, busy_a},
                {tbl[i].se, tbl[i].mr, tbl[i].ret, tbl[i].fl, tbl[i].busy});
            advance();
        end
        settle();
        chk("tbl_instret", ins_a, 64'd2);
        chk("tbl_cycles", cyc_a, 64'd10);

        // No-memory cadence over 30 cycles
        do_reset();
        run_a = 1'b1;
        nret = 0; last_ret = -1;
        for (int c = 0; c < 30; c++) begin
            settle();
            if (ret_a) begin
                if (last_ret >= 0) chk("cadence_gap", 64'(c - last_ret), 64'd3);
                last_ret = c;
                nret++;
            end
            advance();
        end
        settle();
        chk("cadence_retires", 64'(nret), 64'd9);
        chk("cadence_instret", ins_a, 64'd9);
        chk("cadence_cycles", cyc_a, 64'd29);

        // Four wait states
        do_reset();
        need_a = 1'b1;
        held = 0; r0_c = -1; ret_c = -1;
        for (int c = 0; c < 10; c++) begin
            run_a = (c == 0);
            rdy_a = (c == 6);
            settle();
            if (se_a[1] && mr_a) held++;
            if (se_a[0] && r0_c < 0) r0_c = c;
            if (ret_a && ret_c < 0) ret_c = c;
            advance();
        end
        chk("wait_first_stage0", 64'(r0_c), 64'd1);
        chk("wait_held", 64'(held), 64'd5);
        chk("wait_latency", 64'(ret_c - r0_c + 1), 64'd7);

        // Timeout with mem_ready never arriving, then arriving on the last cycle
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            run_a = 1'b1; need_a = 1'b1;
            for (int c = 0; c < 16; c++) begin
                rdy_a = (pass == 1) && (c == 10);
                settle();
                if (pass == 0) begin
                    chk($sformatf("tmo_flush_c%0d", c), 64'(fl_a), 64'(c == 10));
                    chk($sformatf("tmo_err_c%0d", c), 64'(err_a), 64'(c >= 11));
                    if (c >= 11) chk("tmo_dead_stage_en", {se_a, busy_a}, 64'd0);
                end else begin
                    chk($sformatf("late_rdy_flush_c%0d", c), 64'(fl_a), 64'd0);
                    chk($sformatf("late_rdy_err_c%0d", c), 64'(err_a), 64'd0);
                    if (c == 11) chk("late_rdy_retire", 64'(ret_a), 64'd1);
                end
                advance();
            end
        end

        // Asynchronous reset while in MEM_WAIT
        do_reset();
        run_a = 1'b1; need_a = 1'b1;
        for (int c = 0; c < 4; c++) step();
        settle();
        chk("prereset_busy", {busy_a, mr_a}, 64'd3);
        x_reset = 1'b0;
        #1;
        chk("async_reset_outputs", {se_a, mr_a, ret_a, fl_a, busy_a, err_a}, 64'd0);
        chk("async_reset_counters", cyc_a | ins_a, 64'd0);
        do_reset();

        // Five-stage sweep with memory in stage 2, then instret wrap at 4 bits
        run_b = 1'b1; need_b = 1'b1; rdy_b = 1'b1;
        nret = 0; seen15 = 1'b0; seen16 = 1'b0; one5 = 5'd1;
        for (int c = 0; c < 100; c++) begin
            settle();
            if (c >= 1 && c <= 5) begin
                chk($sformatf("sweep_stage%0d", c - 1), 64'(se_b), 64'(one5 << (c - 1)));
                chk($sformatf("sweep_memreq%0d", c - 1), 64'(mr_b), 64'(c == 3));
            end
            if (nret == 15 && !seen15) begin
                chk("wrap_instret15", 64'(ins_b), 64'd15);
                seen15 = 1'b1;
            end
            if (nret == 16 && !seen16) begin
                chk("wrap_instret0", 64'(ins_b), 64'd0);
                seen16 = 1'b1;
            end
            if (ret_b) nret++;
            advance();
        end
        chk("wrap_reached", 64'(seen16), 64'd1);

        // Randomized traffic on both configurations
        do_reset();
        dead_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            run_a  = ($urandom_range(0, 9) != 0);
            need_a = ($urandom_range(0, 1) == 1);
            rdy_a  = ($urandom_range(0, 9) < 3);
            trap_a = ($urandom_range(0, 19) == 0);
            run_b  = ($urandom_range(0, 9) != 0);
            need_b = ($urandom_range(0, 1) == 1);
            rdy_b  = ($urandom_range(0, 9) < 3);
            trap_b = ($urandom_range(0, 19) == 0);
            step();
            if (ma.dead || mb.dead) dead_cnt++;
            if (dead_cnt > 4 || $urandom_range(0, 299) == 0) begin
                dead_cnt = 0;
                do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_stage_seq.md
# riscv_stage_seq

Parametrised stage sequencer for the next-generation core. It replaces the fixed divide-by-3 clock generator with one-hot stage enables on the single core clock, and adds a data-memory wait-state handshake, trap flush, a stall timeout, and cycle/instret counters. All core state elements (pc, regs, csr_regs, ram) run on `clk` and are qualified by `stage_en`/`retire` from this block.

## Interface
- `NUM_STAGES`, default 3: stages per instruction; legal range 3..8.
- `MEM_STAGE`, default 1: stage that issues data-memory requests; legal range 1..NUM_STAGES-2.
- `TIMEOUT`, default 255: maximum MEM_WAIT cycles before an error; legal range 1..65535.
- `CNT_W`, default 64: width of each counter.

Ports:
- `clk`  in  1  core clock; everything is rising-edge.
- `x_reset`  in  1  asynchronous, active-low reset.
- `run`  in  1  allows new instructions to start.
- `mem_need`  in  1  current instruction accesses data memory; sampled only in MEM_STAGE.
- `mem_ready`  in  1  memory completes the access this cycle.
- `trap`  in  1  abort the current instruction.
- `stage_en`  out  NUM_STAGES  one-hot stage enable.
- `mem_req`  out  1  data-memory request.
- `retire`  out  1  commit strobe; gates pc, rf and csr writes.
- `flush`  out  1  instruction aborted this cycle.
- `busy`  out  1  state is RUN or MEM_WAIT.
- `err`  out  1  sticky stall-timeout flag.
- `cycle_cnt`  out  CNT_W  active-cycle counter.
- `instret_cnt`  out  CNT_W  retired-instruction counter.

## Operation
- **States:** IDLE, RUN(k) for k = 0..NUM_STAGES-1, MEM_WAIT, ERROR. Stage index `k` is a register.
- **Reset:**
  - state IDLE, k = 0, wait counter = 0.
  - `stage_en` = 0, `mem_req` = `retire` = `flush` = `busy` = `err` = 0.
  - both counters = 0.
- **IDLE:** `run` = 1 moves to RUN(0) on the next cycle.
- **RUN(k), general:** `stage_en[k]` = 1 for exactly one cycle, then RUN(k+1).
- **RUN(MEM_STAGE):**
  - `mem_req` = `mem_need` (combinational).
  - `mem_need` = 1 and `mem_ready` = 0: go to MEM_WAIT.
  - Otherwise advance to RUN(MEM_STAGE+1).
- **MEM_WAIT:**
  - `stage_en[MEM_STAGE]` = 1 and `mem_req` = 1 are held.
  - Wait counter increments every cycle.
  - `mem_ready` = 1: go to RUN(MEM_STAGE+1) and clear the wait counter.
- **RUN(NUM_STAGES-1):**
  - `retire` = `stage_en[NUM_STAGES-1]` & ~`trap`.
  - `instret_cnt` increments on retire.
  - Next state is RUN(0) if `run` = 1, else IDLE.
- **Trap:** `trap` = 1 in RUN or MEM_WAIT does the following in the same cycle:
  - `flush` = 1 and `retire` is suppressed.
  - `mem_req` is forced to 0.
  - Next state is RUN(0) if `run`, else IDLE; wait counter clears.
  - `trap` is ignored in IDLE and ERROR.
- **Timeout:**
  - Fires in MEM_WAIT when the wait counter = TIMEOUT-1 and `mem_ready` = 0.
  - Effects: `flush` = 1 that cycle, `err` is set, next state ERROR.
  - ERROR: `stage_en` = 0, `busy` = 0, no further activity until reset.
- **Priority within a cycle:** `trap` > `mem_ready` > timeout. `mem_ready` on the timeout cycle completes normally.
- **`run` deassertion:** never aborts the instruction in flight. It only prevents the next RUN(0).
- **Counters:**
  - `cycle_cnt` increments every cycle the state is RUN or MEM_WAIT.
  - Both counters wrap modulo 2^CNT_W with no saturation.
- **Reset mid-operation:** all state returns to reset values immediately. No retire or flush is emitted.

## Timing
- Registered: state, k, wait counter, `err`, both counters.
- Combinational from state and inputs: `stage_en`, `busy`, `mem_req`, `retire`, `flush`.
- No-memory instruction: NUM_STAGES cycles from RUN(0) to retire.
- Memory instruction: NUM_STAGES + W cycles, where W is the number of cycles `mem_ready` is low after the request.
- With defaults, back-to-back non-memory instructions retire every 3 cycles, matching the old clk3 cadence.
- Counter updates are visible the cycle after the qualifying event.
- `err` rises the cycle after the timeout cycle.
- After reset release with `run` = 1: first `stage_en[0]` appears in the 2nd cycle.

## Test plan
1. **No-memory cadence.** Defaults, `run` = 1, `mem_need` = 0 for 30 cycles → `retire` pulses every 3rd cycle; `instret_cnt` = 9 or 10; `cycle_cnt` = 29.
2. **Wait states.** `mem_need` = 1, `mem_ready` delayed 4 cycles → `stage_en[1]` and `mem_req` held for 5 cycles; retire 7 cycles after RUN(0).
3. **Trap priority.** `trap` coincident with `mem_ready` in MEM_WAIT → `flush` = 1, `retire` = 0, `instret_cnt` unchanged, next `stage_en` = 3'b001.
4. **Timeout.**
   - TIMEOUT = 8, `mem_ready` never asserted → `flush` pulse on the 8th MEM_WAIT cycle; `err` = 1 next cycle; `stage_en` = 0 permanently.
   - Repeat with `mem_ready` on that cycle → normal completion and `err` = 0.
5. **`run` low and async reset.**
   - `run` dropped in RUN(1) → that instruction still retires, then IDLE with `busy` = 0.
   - `x_reset` low in MEM_WAIT → all outputs 0 asynchronously.
6. **Parametrisation and wrap.**
   - NUM_STAGES = 5, MEM_STAGE = 2 → one-hot sweep 00001..10000; `mem_req` only in stage 2.
   - CNT_W = 4 → `instret_cnt` wraps 15→0.
